// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: execute-phase data port bundle.
//   mem_addr/st_data/we : requester -> memory (sampled every posedge)
//   ld_data/ready/addr_err : memory -> requester
interface data_memory_responder_if #(
  parameter int ADDR_W = 16,
  parameter int REG_W  = 64
);
  logic [ADDR_W-1:0]  mem_addr;
  logic [REG_W-1:0]   st_data;
  logic [REG_W/8-1:0] we;
  logic [REG_W-1:0]   ld_data;
  logic               ready;
  logic               addr_err;
  modport master (output mem_addr, st_data, we, input ld_data, ready, addr_err);
  modport slave  (input mem_addr, st_data, we, output ld_data, ready, addr_err);
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-array backed data memory with fixed load latency.
//   clk  : clock, all state on posedge
//   rstn : asynchronous active-low reset
//   bus  : slave side of data_memory_responder_if (address/store/lane enables in,
//          ld_data/ready/addr_err out)
module data_memory_responder #(
  parameter int LOAD_LATENCY = 1,
  parameter int DEPTH_LOG2   = 10,
  parameter int ADDR_W       = 16,
  parameter int REG_W        = 64
) (
  input logic clk,
  input logic rstn,
  data_memory_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {INIT, RUN} state_t;
  state_t                state;
  logic [DEPTH_LOG2-1:0] cnt;
  logic                  ready_q;
  logic                  addr_err_q;
  logic [REG_W-1:0]      mem [DEPTH];
  logic [REG_W-1:0]      pipe [LOAD_LATENCY];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic [REG_W-1:0]      old_word;
  logic [REG_W-1:0]      merged;
  logic                  run;
  assign idx      = bus.mem_addr[DEPTH_LOG2-1:0];
  assign in_range = bus.mem_addr[ADDR_W-1:DEPTH_LOG2] == '0;
  assign old_word = mem[idx];
  assign run      = state == RUN;
  // Write-first: the read path sees the lane-merged word of this cycle's store.
  for (genvar i = 0; i < REG_W / 8; i++) begin : g_lane
    assign merged[8*i+:8] = bus.we[i] ? bus.st_data[8*i+:8] : old_word[8*i+:8];
  end
  // Array has no reset; the INIT sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT) mem[cnt] <= '0;
    else if (in_range && |bus.we) mem[idx] <= merged;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= INIT;
      cnt        <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end else if (!in_range) begin
      addr_err_q <= 1'b1;
    end
  end
  // Each stage is a snapshot; later writes never touch in-flight data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LOAD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= (run && in_range) ? merged : '0;
      for (int i = 1; i < LOAD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.ld_data  = pipe[LOAD_LATENCY-1];
  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for data_memory_responder.
module tb_data_memory_responder;
  localparam int L     = 2;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  logic clk = 0;
  logic rstn = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  typedef struct {
    logic [63:0] e;
    int          due;
    string       nm;
  } exp_t;
  exp_t q[$];
  data_memory_responder_if #(.ADDR_W(8), .REG_W(64)) bus ();
  data_memory_responder #(.LOAD_LATENCY(L), .DEPTH_LOG2(DL2), .ADDR_W(8), .REG_W(64)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (x.due != cyc || bus.ld_data !== x.e) begin
        errors++;
        $display("FAIL %s ld_data got %h exp %h (cycle %0d due %0d)", x.nm, bus.ld_data, x.e, cyc, x.due);
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask
  task automatic acc(input logic [7:0] a, input logic [7:0] w, input logic [63:0] d,
                     input logic [63:0] e, input string nm);
    exp_t x;
    bus.mem_addr = a;
    bus.we       = w;
    bus.st_data  = d;
    x.e = e; x.due = cyc + L; x.nm = nm;
    q.push_back(x);
    @(negedge clk);
    bus.we = '0;
  endtask
  task automatic drain();
    repeat (L + 2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
      q.delete();
    end
  endtask
  task automatic wait_init(input string nm);
    int n = 0;
    while (!bus.ready && n < 4 * DEPTH) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'(DEPTH));
  endtask
  initial begin
    bus.mem_addr = 0; bus.we = 0; bus.st_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 0);
    chk("rst_ld", bus.ld_data, 0);
    chk("rst_err", 64'(bus.addr_err), 0);
    rstn = 1;
    bus.mem_addr = 8'd3; bus.we = 8'hff; bus.st_data = '1;
    wait_init("init_len");
    bus.we = 0; bus.st_data = 0;
    acc(8'd0, 0, 0, 0, "t1_rd0");
    acc(8'(DEPTH - 1), 0, 0, 0, "t1_rd_last");
    acc(8'd3, 0, 0, 0, "t1_init_ignored");
    acc(8'd5, 8'hff, 64'h1122334455667788, 64'h1122334455667788, "t2_wr5");
    acc(8'd5, 0, 0, 64'h1122334455667788, "t2_rd5");
    acc(8'd5, 8'h08, 64'h00000000AB000000, 64'h11223344AB667788, "t3_lane_wr");
    acc(8'd5, 0, 0, 64'h11223344AB667788, "t3_rd5");
    acc(8'd7, 8'h0f, 64'h00000000DEADBEEF, 64'h00000000DEADBEEF, "t4_rdw7");
    acc(8'd5, 0, 0, 64'h11223344AB667788, "t4_b2b5a");
    acc(8'd7, 0, 0, 64'h00000000DEADBEEF, "t4_b2b7");
    acc(8'd5, 0, 0, 64'h11223344AB667788, "t4_b2b5b");
    acc(8'd9, 8'hff, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, "snap_a");
    acc(8'd9, 8'hf0, 64'h5555555500000000, 64'h55555555AAAAAAAA, "snap_b");
    acc(8'd9, 0, 0, 64'h55555555AAAAAAAA, "snap_rd");
    drain();
    chk("t5_err_pre", 64'(bus.addr_err), 0);
    acc(8'(DEPTH), 8'hff, '1, 0, "t5_oor_wr");
    acc(8'(DEPTH + 5), 0, 0, 0, "t5_oor_alias_rd");
    acc(8'd0, 0, 0, 0, "t5_word0");
    acc(8'd5, 0, 0, 64'h11223344AB667788, "t5_word5");
    drain();
    chk("t5_err", 64'(bus.addr_err), 1);
    bus.mem_addr = 8'd5;
    @(posedge clk); @(posedge clk); #1;
    chk("t6_inflight", bus.ld_data, 64'h11223344AB667788);
    #2 rstn = 0;
    #1;
    chk("t6_ld_drop", bus.ld_data, 0);
    chk("t6_ready_drop", 64'(bus.ready), 0);
    chk("t6_err_clr", 64'(bus.addr_err), 0);
    @(negedge clk);
    rstn = 1;
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rstn = 0;
    #1;
    chk("t6_midinit_ready", 64'(bus.ready), 0);
    @(negedge clk);
    rstn = 1;
    wait_init("t6_init_len");
    for (int i = 0; i < DEPTH; i++) acc(8'(i), 0, 0, 0, $sformatf("t6_clr%0d", i));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
